// File: rtl/uart_pkg.sv
// Shared UART definitions: frame shape, default bit timing and receiver FSM encoding.
package uart_pkg;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned STOP_BITS        = 1;
  localparam int unsigned CLKS_PER_BIT_DEF = 104;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t StIdle  = 2'd0;
  localparam uart_state_t StStart = 2'd1;
  localparam uart_state_t StData  = 2'd2;
  localparam uart_state_t StStop  = 2'd3;

  // Mid-bit offset used to centre sampling inside the start bit.
  function automatic int unsigned half_bit(input int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level input, with a selectable reset value.
module sync_2ff #(
  parameter int unsigned Width    = 1,
  parameter logic        ResetVal = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= {Width{ResetVal}};
      sync_q <= {Width{ResetVal}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check, valid/ready output with overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ftdi_rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int unsigned IdxW = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HalfCnt = CNT_W'(half_bit(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] BitLast = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0]  IdxLast = IdxW'(DATA_BITS - 1);

  logic rx_s;

  uart_state_t          state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [IdxW-1:0]      bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [7:0]           rx_data_q,   rx_data_d;
  logic                 rx_valid_q,  rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;

  sync_2ff #(
    .Width    (1),
    .ResetVal (1'b1)
  ) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ftdi_rx_i),
    .q_o   (rx_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;

    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (cnt_q == HalfCnt) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A high sample here means the falling edge was a glitch.
          state_d   = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d        = bit_idx_q + 1'b1;
          if (bit_idx_q == IdxLast) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_s) begin
            rx_data_d = shift_q;
            // An accept on this same edge frees the slot, so it is not an overrun.
            if (rx_valid_q && !rx_ready_i) begin
              overrun_d = 1'b1;
            end
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames are driven on the pin and accepted bytes are
// checked against a queue of expected bytes.
module tb_uart_rx;

  localparam int unsigned Cpb    = 16;
  localparam int unsigned ClkPer = 10;
  localparam int unsigned BitT   = Cpb * ClkPer;

  logic       clk;
  logic       rst_n;
  logic       ftdi_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_count = 0;
  int fe_long  = 0;
  bit fe_prev  = 1'b0;

  logic [7:0] exp_q[$];

  uart_rx #(
    .CLKS_PER_BIT (Cpb),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ftdi_rx_i   (ftdi_rx),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .frame_err_o (frame_err),
    .overrun_o   (overrun)
  );

  initial clk = 1'b0;
  always #(ClkPer / 2) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bt,
                           input bit expect_ok);
    if (expect_ok) exp_q.push_back(b);
    ftdi_rx = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      ftdi_rx = b[i];
      #(bt);
    end
    ftdi_rx = stop_bit;
    #(bt);
    ftdi_rx = 1'b1;
  endtask

  // Every accepted byte must be the oldest expected one; an unexpected byte compares to X.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) begin
        fe_count++;
        if (fe_prev) fe_long++;
      end
      fe_prev = frame_err;
      if (rx_valid && rx_ready) begin
        logic [7:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        chk("rx_data", {24'h0, rx_data}, {24'h0, e});
      end
    end else begin
      fe_prev = 1'b0;
    end
  end

  initial begin
    int fe_base;
    int bt;
    logic [7:0] rb;

    rst_n    = 1'b0;
    ftdi_rx  = 1'b1;
    rx_ready = 1'b1;
    wait_clks(4);
    chk("reset_rx_data", {24'h0, rx_data}, 32'h00);
    chk("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("reset_frame_err", {31'h0, frame_err}, 32'h0);
    chk("reset_overrun", {31'h0, overrun}, 32'h0);
    rst_n = 1'b1;
    wait_clks(4);

    // Single byte, consumer always ready.
    send_byte(8'h47, 1'b1, BitT, 1'b1);
    wait_clks(4);
    chk("g_delivered", exp_q.size(), 32'd0);
    chk("g_valid_cleared", {31'h0, rx_valid}, 32'h0);
    chk("g_no_frame_err", fe_count, 32'd0);
    chk("g_no_overrun", {31'h0, overrun}, 32'h0);

    // Back-to-back bytes with the consumer stalled: the second overwrites and flags overrun.
    rx_ready = 1'b0;
    send_byte(8'h55, 1'b1, BitT, 1'b0);
    chk("ovr_first_valid", {31'h0, rx_valid}, 32'h1);
    chk("ovr_first_data", {24'h0, rx_data}, 32'h55);
    chk("ovr_first_no_overrun", {31'h0, overrun}, 32'h0);
    send_byte(8'hAA, 1'b1, BitT, 1'b1);
    chk("ovr_second_valid", {31'h0, rx_valid}, 32'h1);
    chk("ovr_second_data", {24'h0, rx_data}, 32'hAA);
    chk("ovr_overrun_set", {31'h0, overrun}, 32'h1);
    wait_clks(Cpb);
    chk("ovr_held_data", {24'h0, rx_data}, 32'hAA);
    rx_ready = 1'b1;
    wait_clks(3);
    chk("ovr_drained", exp_q.size(), 32'd0);
    chk("ovr_valid_cleared", {31'h0, rx_valid}, 32'h0);
    chk("ovr_sticky", {31'h0, overrun}, 32'h1);

    // Stop bit low: one single-cycle frame error, no byte, then recovery.
    fe_base = fe_count;
    send_byte(8'h3C, 1'b0, BitT, 1'b0);
    wait_clks(2 * Cpb);
    chk("fe_one_pulse", fe_count - fe_base, 32'd1);
    chk("fe_pulse_width", fe_long, 32'd0);
    chk("fe_no_valid", {31'h0, rx_valid}, 32'h0);
    send_byte(8'h01, 1'b1, BitT, 1'b1);
    wait_clks(4);
    chk("fe_recover", exp_q.size(), 32'd0);

    // Short low glitch on the idle line is rejected silently.
    fe_base = fe_count;
    ftdi_rx = 1'b0;
    wait_clks(Cpb / 4);
    ftdi_rx = 1'b1;
    wait_clks(3 * Cpb);
    chk("glitch_no_frame_err", fe_count - fe_base, 32'd0);
    chk("glitch_no_valid", {31'h0, rx_valid}, 32'h0);
    send_byte(8'hFF, 1'b1, BitT, 1'b1);
    wait_clks(4);
    chk("glitch_recover", exp_q.size(), 32'd0);

    // Reset during bit 4 of 8'hF0: partial byte dropped, all outputs cleared.
    ftdi_rx = 1'b0;
    #(5 * BitT);
    ftdi_rx = 1'b1;
    #(BitT / 2);
    rst_n = 1'b0;
    #(2 * ClkPer);
    chk("rst_mid_rx_data", {24'h0, rx_data}, 32'h00);
    chk("rst_mid_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_mid_frame_err", {31'h0, frame_err}, 32'h0);
    chk("rst_mid_overrun", {31'h0, overrun}, 32'h0);
    rst_n = 1'b1;
    #(BitT / 2 - 2 * ClkPer + 4 * BitT);
    wait_clks(2);
    chk("rst_no_stray_valid", {31'h0, rx_valid}, 32'h0);
    send_byte(8'h0F, 1'b1, BitT, 1'b1);
    wait_clks(4);
    chk("rst_recover", exp_q.size(), 32'd0);

    // 16 random bytes, back-to-back, alternating roughly +/-2% bit-period skew.
    fe_base = fe_count;
    for (int i = 0; i < 16; i++) begin
      rb = 8'($urandom_range(0, 255));
      bt = (i % 2 == 0) ? (BitT - 3) : (BitT + 3);
      send_byte(rb, 1'b1, bt, 1'b1);
    end
    wait_clks(4);
    chk("skew_all_delivered", exp_q.size(), 32'd0);
    chk("skew_no_frame_err", fe_count - fe_base, 32'd0);
    chk("skew_no_overrun", {31'h0, overrun}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the FTDI serial link on the iCE40 tester; the counterpart of the existing transmitter.
- Synchronises the asynchronous `ftdi_rx` line and times each bit with a per-bit clock counter.
- Samples at mid-bit, checks the stop bit, and presents each byte on a valid/ready handshake to downstream test logic.
- Reports framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 104: clock cycles per UART bit (12 MHz / 115200). Legal range 4..65535.
- CNT_W, 16: width of the bit-timing counter. Must hold CLKS_PER_BIT-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous assert, active-low
- ftdi_rx  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  8  received byte, LSB first on the wire; stable while rx_valid=1
- rx_valid  output  1  byte available; held until accepted
- rx_ready  input  1  consumer accepts; transfer occurs when rx_valid & rx_ready at a rising clk edge
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  sticky: a byte completed while rx_valid was still 1; cleared only by reset

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low. All state clears immediately on rst_n=0.
- Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, FSM=IDLE, synchroniser flops=1.
- Synchroniser: 2-flop chain on ftdi_rx, giving `rx_s`. All decoding uses rx_s, which lags the pin by 2 cycles.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Counter held at 0.
  - On rx_s=0, go to START and clear the counter.
- START:
  - Count to HALF = CLKS_PER_BIT/2 (integer divide), then sample rx_s.
  - If the sample is 0: start bit valid; clear the counter and bit index; go to DATA.
  - If the sample is 1: glitch; return to IDLE with no output and no error.
- DATA:
  - Count 0..CLKS_PER_BIT-1. At terminal count, sample rx_s into shift[bit_idx] (LSB first) and increment bit_idx.
  - After the 8th sample (bit_idx wraps 7→0), go to STOP.
- STOP:
  - At terminal count, sample rx_s.
  - If 1: load rx_data←shift and set rx_valid=1 on the next edge.
  - If 0: pulse frame_err for exactly one cycle and discard the byte (rx_data/rx_valid unchanged).
  - Either way, return to IDLE.
  - Sampling is mid-bit, so the remaining half stop bit is spent in IDLE. A new start edge is detected only once rx_s=0.
- Latency: rx_valid rises 2 + HALF + 9·CLKS_PER_BIT + 1 clk after the falling start edge at the pin (±1 for phase).
- Handshake:
  - rx_valid stays high and rx_data stays stable until a cycle with rx_ready=1.
  - rx_valid clears on the edge after that cycle.
  - rx_ready while rx_valid=0 is ignored.
- Simultaneous accept and new byte (same edge): the new byte loads, rx_valid stays 1, no overrun.
- Overrun: a new good byte with rx_valid=1 and rx_ready=0 overwrites rx_data, keeps rx_valid=1, and sets overrun=1.
- Line held low (break): the frame is rejected by frame_err. The FSM stays in IDLE→START→DATA cycles while low, with no rx_valid. Each all-zero frame emits one frame_err.
- Reset mid-frame: the partial byte is discarded and the FSM restarts in IDLE. The next start bit must be a full fresh edge.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE/START/DATA/STOP, 2-bit).
  - Frame constants DATA_BITS=8 and STOP_BITS=1.
  - Default CLKS_PER_BIT=104, shared by uart_tx and uart_rx.
- Sub-module `sync_2ff` (2-flop synchroniser with reset value parameter) is natural and reusable for other async inputs.

Test Plan:
- CLKS_PER_BIT=16; send 8'h47 ('G'), rx_ready=1 → rx_valid pulses 1 cycle with rx_data=8'h47; frame_err=0, overrun=0.
- Send 8'h55, then 8'hAA back-to-back (stop bit then immediate start), rx_ready=0 until both done → after the first byte rx_data=8'h55, rx_valid=1 held; after the second rx_data=8'hAA, overrun=1.
- Send 8'h3C with stop bit driven 0 → frame_err single-cycle pulse at the stop sample; rx_valid stays 0; the next good byte 8'h01 is received correctly.
- Drive a 0 glitch of CLKS_PER_BIT/4 cycles on the idle line → no rx_valid, no frame_err, FSM back in IDLE; a following 8'hFF is received.
- Assert rst_n=0 during bit 4 of 8'hF0, release, send 8'h0F → only 8'h0F delivered; all outputs 0 during reset.
- Hold rx_ready=1 continuously, 16 random bytes at ±2% baud skew → all bytes match in order; no errors.
